pc_ctrl: RTL

//  Consumer end of the EX->ctrl interface (jump_en/jump_addr/hold_flag). Owns the

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/pc_ctrl_if.sv | 24 ++
 rtl/pc_ctrl_perf_cnt.sv | 19 +
 rtl/pc_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC controller: FSM state encoding, PC step, NOP word.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    PCC_ST_RUN   = 2'd0,
    PCC_ST_FLUSH = 2'd1,
    PCC_ST_HOLD  = 2'd2
  } pcc_state_t;

  localparam logic [31:0] PC_STEP  = 32'h0000_0004;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// EX->ctrl request bundle plus the controller's PC, flush/stall and perf-counter outputs.
interface pc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      jump_addr_i;
  logic             jump_en_i;
  logic             hold_flag_i;
  logic [31:0]      pc_o;
  logic             flush_o;
  logic             stall_o;
  logic [CNT_W-1:0] jump_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             misalign_o;

  modport master (
    output jump_addr_i, jump_en_i, hold_flag_i,
    input  pc_o, flush_o, stall_o, jump_cnt_o, stall_cnt_o, misalign_o
  );

  modport slave (
    input  jump_addr_i, jump_en_i, hold_flag_i,
    output pc_o, flush_o, stall_o, jump_cnt_o, stall_cnt_o, misalign_o
  );
endinterface

// File: rtl/pc_ctrl_perf_cnt.sv
// Free-running event counter: increments on inc, wraps silently at 2^CNT_W.
module pc_ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC controller: owns the architectural PC, sequences jump flushes and EX stalls.
// Optional macro PC_CTRL_MISALIGN_TRAP_EN: misaligned jump targets are refused and flagged.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 32
) (
  input logic      clk,
  input logic      rst,
  pc_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  pcc_state_t       state, state_nxt;
  logic [2:0]       flush_cnt, flush_cnt_nxt;
  logic [31:0]      pc, pc_nxt, target;
  logic             take_jump, trap;
  logic             flush, stall, jump_inc, stall_inc;
  logic [CNT_W-1:0] jump_cnt, stall_cnt;

  // Requests from EX are only meaningful outside FLUSH; EX is holding NOPs then.
  assign take_jump = (state != PCC_ST_FLUSH) && bus.jump_en_i;

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  logic misalign;

  assign trap   = |bus.jump_addr_i[1:0];
  assign target = bus.jump_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= take_jump && trap;
    end
  end

  assign bus.misalign_o = misalign;
`else
  assign trap           = 1'b0;
  assign target         = bus.jump_addr_i & ~32'h0000_0003;
  assign bus.misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PCC_ST_RUN;
      flush_cnt <= '0;
      pc        <= RESET_ADDR;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pc        <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      PCC_ST_FLUSH: begin
        flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt <= 3'd1) state_nxt = PCC_ST_RUN;
      end
      default: begin
        if (bus.jump_en_i) begin
          // A refused misaligned jump still runs the full flush sequence.
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = PCC_ST_FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            state_nxt = PCC_ST_RUN;
          end
        end else if (bus.hold_flag_i) begin
          state_nxt = PCC_ST_HOLD;
        end else begin
          state_nxt = PCC_ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    flush     = 1'b0;
    stall     = 1'b0;
    jump_inc  = 1'b0;
    stall_inc = 1'b0;
    if (!rst) begin
      if (state == PCC_ST_FLUSH) begin
        flush = 1'b1;
      end else if (bus.jump_en_i) begin
        flush    = 1'b1;
        jump_inc = !trap;
      end else if (bus.hold_flag_i) begin
        stall     = 1'b1;
        stall_inc = 1'b1;
      end
    end
  end

  always_comb begin
    pc_nxt = pc_advance(pc);
    if (take_jump) begin
      if (!trap) begin
        pc_nxt = target;
      end else if (state == PCC_ST_HOLD && bus.hold_flag_i) begin
        pc_nxt = pc;
      end
    end else if (state != PCC_ST_FLUSH && bus.hold_flag_i) begin
      pc_nxt = pc;
    end
  end

  pc_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_jump_cnt (
    .clk (clk),
    .rst (rst),
    .inc (jump_inc),
    .cnt (jump_cnt)
  );

  pc_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  assign bus.pc_o        = pc;
  assign bus.flush_o     = flush;
  assign bus.stall_o     = stall;
  assign bus.jump_cnt_o  = jump_cnt;
  assign bus.stall_cnt_o = stall_cnt;

endmodule
